unary_rate_mul: RTL and testbench
=================================

Name: unary_rate_mul

Overview:
- Upstream feeder of the unary-rate accumulator in each PE of the 8-bit unary-rate systolic array.
- Takes one signed input/weight pair per operation and converts it to a rate-coded bitstream:
  - Input magnitude is rate-coded against a low-discrepancy sequence.
  - Weight magnitude is temporally coded as the stream length.
- Drives the accumulator's en/clr/acc/sign_i/sign_w/prod_bit controls cycle by cycle.
- Reports busy/done to the PE controller.

Parameters:
- WIDTH, 8, two's-complement width of i_data/w_data; magnitude width MAG = WIDTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  launch one multiply; sampled only in IDLE.
- abort  in  1  synchronous abort/clear request.
- acc_i  in  1  first pair of a dot product; forwarded as acc on the first stream cycle.
- i_data  in  WIDTH  signed input activation.
- w_data  in  WIDTH  signed weight.
- busy  out  1  operation in progress (RUN or DONE).
- done  out  1  one-cycle pulse, stream finished.
- en  out  1  accumulator enable, one per stream bit.
- clr  out  1  accumulator clear pulse.
- acc  out  1  accumulator load-with-input-data strobe.
- sign_i  out  1  sign of latched input.
- sign_w  out  1  sign of latched weight.
- prod_bit  out  1  unary product bit.

Behaviour:
Reset and register policy:
- All outputs are registered. Reset values: busy=0, done=0, en=0, clr=0, acc=0, sign_i=0, sign_w=0, prod_bit=0.
- Reset also clears internal state: FSM=IDLE, cnt=0, latched magnitudes=0, acc flag=0.
- rst_n low mid-stream aborts immediately. No residual en pulse after release.

FSM states: IDLE, RUN, DONE.

IDLE:
- start=1 latches the following on the same edge:
  - sign_i=i_data[WIDTH-1] and sign_w=w_data[WIDTH-1].
  - mag_i=|i_data| and mag_w=|w_data|, each saturated to 2^MAG-1 (so -128 gives 127 at WIDTH=8).
  - acc flag=acc_i.
- Sets cnt=0.
- Next state: RUN if mag_w!=0, else DONE directly with no en pulse.

RUN, one stream bit per cycle:
- Outputs: en=1, prod_bit=(rng < mag_i), where rng = bit-reverse of cnt[MAG-1:0].
- acc=1 only on the first RUN cycle and only if the acc flag is set; otherwise acc=0.
- Counter: cnt increments each cycle. The cycle with cnt==mag_w-1 is the last; then go to DONE.
- Stream length is exactly mag_w cycles.

DONE:
- One cycle, done=1, en=0, then IDLE.
- busy=1 in RUN and DONE.

Latency:
- start accepted at edge t gives the first en high in cycle t+1 (RUN entry) and done in cycle t+1+mag_w.

start handling:
- start while busy is ignored, and no queueing.
- start in the same cycle done is high is also ignored; the controller restarts the next cycle.

abort:
- Highest priority, any state.
- Next cycle: clr=1 for exactly one cycle, en=0, acc=0, done=0, busy=0, FSM=IDLE, cnt=0.
- start in the same cycle as abort is ignored.

sign_i/sign_w:
- Held stable from RUN entry through DONE.
- Retained in IDLE until the next accepted start.

Optional Feature:
- Macro: UNARY_RATE_MUL_LFSR_EN.
- Defined:
  - rng comes from a MAG-bit maximal-length Fibonacci LFSR, seed 1, reset to 1 on rst_n and on each accepted start.
  - Advances one step per RUN cycle. Value 0 never occurs.
  - prod_bit=(rng <= mag_i), with mag_i==0 forced to prod_bit=0.
- Undefined: bit-reversed counter as above. Interface and timing are identical either way.

Test Plan:
- Rate coding: WIDTH=8, i=64, w=4, acc_i=1, start -> en high 4 cycles; prod_bit 1,0,1,0; acc high on first en cycle only; done pulse in cycle t+5.
- Saturation: i=-128, w=127 -> 127 en cycles; prod_bit all 1; sign_i=1, sign_w=0; done in cycle t+128.
- Zero weight: i=55, w=0 -> no en pulse; done=1 in cycle t+1; busy high that cycle only.
- Negative signs: i=-3, w=-2 -> sign_i=sign_w=1 held; en 2 cycles; prod_bit 1,0 (rng 0,64 vs 3).
- Abort mid-stream: i=100, w=10, abort on 3rd RUN cycle -> next cycle clr=1 (single cycle), en=0, busy=0, no done. start accepted the following cycle.
- Ignored start / reset: start pulsed during RUN leaves stream length unchanged. rst_n low mid-RUN gives all outputs 0 asynchronously; FSM idles after release.

Source files
------------

// File: rtl/unary_rate_mul.sv
// unary_rate_mul
//   Converts one signed input/weight pair into a unary-rate product bitstream
//   for the PE accumulator.  The input magnitude is rate coded against a
//   low-discrepancy sequence; the weight magnitude sets the stream length.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             launch one multiply (sampled only in IDLE)
//   abort             synchronous abort/clear request, highest priority
//   acc_i             first pair of a dot product, forwarded as acc
//   i_data, w_data    signed input activation / weight (WIDTH bits)
//   busy, done        operation in progress / one-cycle completion pulse
//   en, clr, acc      accumulator enable / clear pulse / load strobe
//   sign_i, sign_w    latched operand signs
//   prod_bit          unary product bit
//
// Build option
//   UNARY_RATE_MUL_LFSR_EN  use a maximal-length Fibonacci LFSR (seed 1) as
//                           the rate sequence instead of the bit-reversed
//                           counter.  Interface and timing are unchanged.

module unary_rate_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] w_data,
  output logic             busy,
  output logic             done,
  output logic             en,
  output logic             clr,
  output logic             acc,
  output logic             sign_i,
  output logic             sign_w,
  output logic             prod_bit
);

  localparam int MAG = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [MAG-1:0] MAG_ZERO = '0;
  localparam logic [MAG-1:0] MAG_ONE  = MAG'(1);
  localparam logic [MAG-1:0] MAG_MAX  = '1;

  // Magnitude of a two's-complement value, saturated so the most negative
  // code maps to the largest representable magnitude.
  function automatic logic [MAG-1:0] sat_abs(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] a;
    a = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    sat_abs = a[WIDTH-1] ? MAG_MAX : a[MAG-1:0];
  endfunction

`ifdef UNARY_RATE_MUL_LFSR_EN
  // Feedback tap mask for a maximal-length Fibonacci LFSR of n bits.
  function automatic logic [31:0] lfsr_taps(input int n);
    case (n)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      default: lfsr_taps = 32'h0000_0003 << (n - 2);
    endcase
  endfunction

  localparam logic [31:0]    TAPS_FULL = lfsr_taps(MAG);
  localparam logic [MAG-1:0] TAPS      = TAPS_FULL[MAG-1:0];

  // One Fibonacci shift step; the all-zero state is unreachable from seed 1.
  function automatic logic [MAG-1:0] lfsr_step(input logic [MAG-1:0] l);
    lfsr_step = {l[MAG-2:0], ^(l & TAPS)};
  endfunction

  logic [MAG-1:0] lfsr_r, lfsr_s;
`else
  // Bit reversal of the stream counter gives a low-discrepancy sequence.
  function automatic logic [MAG-1:0] bit_rev(input logic [MAG-1:0] x);
    for (int k = 0; k < MAG; k++) begin
      bit_rev[k] = x[MAG-1-k];
    end
  endfunction
`endif

  logic [1:0]     state_r, state_s;
  logic [MAG-1:0] cnt_r, cnt_s;
  logic [MAG-1:0] mag_i_r, mag_i_s;
  logic [MAG-1:0] mag_w_r, mag_w_s;
  logic           acc_flag_r, acc_flag_s;
  logic [MAG-1:0] rng_s;
  logic           busy_s, done_s, en_s, clr_s, acc_s;
  logic           sign_i_s, sign_w_s, prod_s;

  // Next-state and next-output logic; outputs are the registered version of
  // the values for the cycle that follows the current edge.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    mag_i_s    = mag_i_r;
    mag_w_s    = mag_w_r;
    acc_flag_s = acc_flag_r;
    sign_i_s   = sign_i;
    sign_w_s   = sign_w;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    en_s       = 1'b0;
    clr_s      = 1'b0;
    acc_s      = 1'b0;
`ifdef UNARY_RATE_MUL_LFSR_EN
    lfsr_s     = lfsr_r;
`endif
    if (abort) begin
      state_s = S_IDLE;
      cnt_s   = MAG_ZERO;
      clr_s   = 1'b1;
`ifdef UNARY_RATE_MUL_LFSR_EN
      lfsr_s  = MAG_ONE;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            sign_i_s   = i_data[WIDTH-1];
            sign_w_s   = w_data[WIDTH-1];
            mag_i_s    = sat_abs(i_data);
            mag_w_s    = sat_abs(w_data);
            acc_flag_s = acc_i;
            cnt_s      = MAG_ZERO;
            busy_s     = 1'b1;
`ifdef UNARY_RATE_MUL_LFSR_EN
            lfsr_s     = MAG_ONE;
`endif
            if (mag_w_s != MAG_ZERO) begin
              state_s = S_RUN;
              en_s    = 1'b1;
              acc_s   = acc_flag_s;
            end else begin
              // Zero-length stream: report completion without any en pulse.
              state_s = S_DONE;
              done_s  = 1'b1;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_RUN: begin
          busy_s = 1'b1;
          if (cnt_r == (mag_w_r - MAG_ONE)) begin
            state_s = S_DONE;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + MAG_ONE;
            en_s  = 1'b1;
`ifdef UNARY_RATE_MUL_LFSR_EN
            lfsr_s = lfsr_step(lfsr_r);
`endif
          end
        end
        S_DONE: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = MAG_ZERO;
        end
      endcase
    end

`ifdef UNARY_RATE_MUL_LFSR_EN
    rng_s  = lfsr_s;
    prod_s = en_s & (mag_i_s != MAG_ZERO) & (rng_s <= mag_i_s);
`else
    rng_s  = bit_rev(cnt_s);
    prod_s = en_s & (rng_s < mag_i_s);
`endif
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= MAG_ZERO;
      mag_i_r    <= MAG_ZERO;
      mag_w_r    <= MAG_ZERO;
      acc_flag_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      en         <= 1'b0;
      clr        <= 1'b0;
      acc        <= 1'b0;
      sign_i     <= 1'b0;
      sign_w     <= 1'b0;
      prod_bit   <= 1'b0;
`ifdef UNARY_RATE_MUL_LFSR_EN
      lfsr_r     <= MAG_ONE;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      mag_i_r    <= mag_i_s;
      mag_w_r    <= mag_w_s;
      acc_flag_r <= acc_flag_s;
      busy       <= busy_s;
      done       <= done_s;
      en         <= en_s;
      clr        <= clr_s;
      acc        <= acc_s;
      sign_i     <= sign_i_s;
      sign_w     <= sign_w_s;
      prod_bit   <= prod_s;
`ifdef UNARY_RATE_MUL_LFSR_EN
      lfsr_r     <= lfsr_s;
`endif
    end
  end

endmodule

// File: tb/tb_unary_rate_mul.sv
// Directed self-checking bench for unary_rate_mul (WIDTH=8, counter sequence).
module tb_unary_rate_mul;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       acc_i = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic [7:0] w_data = 8'd0;
  logic       busy, done, en, clr, acc, sign_i, sign_w, prod_bit;
  logic [7:0] outs;

  int pass_cnt = 0;
  int total_cnt = 0;
  int en_seen;
  int done_seen;

  unary_rate_mul #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .acc_i(acc_i),
    .i_data(i_data), .w_data(w_data), .busy(busy), .done(done), .en(en),
    .clr(clr), .acc(acc), .sign_i(sign_i), .sign_w(sign_w), .prod_bit(prod_bit)
  );

  always #5 clk = ~clk;

  assign outs = {busy, done, en, clr, acc, sign_i, sign_w, prod_bit};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    #12;
    chk("reset_outs", outs, 8'h00);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", outs, 8'h00);

    // ---- rate coding: i=64, w=4, acc_i=1 -> prod 1,0,1,0 ----
    i_data = 8'd64; w_data = 8'd4; acc_i = 1'b1; start = 1'b1;
    step();
    start = 1'b0; acc_i = 1'b0;
    // busy,done,en,clr,acc,si,sw,prod
    chk("rate_c1", outs, 8'b1010_1001);
    step(); chk("rate_c2", outs, 8'b1010_0000);
    step(); chk("rate_c3", outs, 8'b1010_0001);
    step(); chk("rate_c4", outs, 8'b1010_0000);
    step(); chk("rate_done", outs, 8'b1100_0000);
    step(); chk("rate_idle", outs, 8'b0000_0000);

    // ---- saturation: i=-128, w=127 ----
    i_data = 8'h80; w_data = 8'd127; start = 1'b1;
    step();
    start = 1'b0;
    chk("sat_signs", {sign_i, sign_w}, 2'b10);
    en_seen = 0;
    for (int k = 0; k < 127; k++) begin
      if (en === 1'b1 && prod_bit === 1'b1 && done === 1'b0) en_seen++;
      step();
    end
    chk("sat_en_prod_cycles", en_seen, 127);
    chk("sat_done", outs, 8'b1100_0100);
    step(); chk("sat_idle", {busy, done, en}, 3'b000);

    // ---- zero weight, plus start held during done (ignored) ----
    i_data = 8'd55; w_data = 8'd0; start = 1'b1;
    step();
    chk("zero_w_done", outs, 8'b1100_0000);
    step();
    start = 1'b0;
    chk("start_in_done_ignored", {busy, done, en}, 3'b000);
    step(); chk("zero_w_idle", {busy, done, en}, 3'b000);

    // ---- negative signs: i=-3, w=-2 -> prod 1,0 ----
    i_data = 8'hFD; w_data = 8'hFE; start = 1'b1;
    step();
    start = 1'b0;
    chk("neg_c1", outs, 8'b1010_0111);
    step(); chk("neg_c2", outs, 8'b1010_0110);
    step(); chk("neg_done", outs, 8'b1100_0110);
    step(); chk("neg_idle_signs_kept", outs, 8'b0000_0110);

    // ---- abort on the third RUN cycle ----
    i_data = 8'd100; w_data = 8'd10; start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_run1", {busy, en}, 2'b11);
    step();
    step();
    chk("abort_run3", {busy, en}, 2'b11);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clr", {busy, done, en, clr, acc}, 5'b00010);
    i_data = 8'd5; w_data = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_restart", {busy, done, en, clr, prod_bit}, 5'b10101);
    step(); chk("abort_restart_done", {busy, done, en, clr}, 4'b1100);
    step(); chk("abort_restart_idle", {busy, done, en}, 3'b000);

    // ---- start together with abort is ignored ----
    i_data = 8'd7; w_data = 8'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_same", {busy, en, clr}, 3'b001);
    step(); chk("start_abort_idle", {busy, en, clr}, 3'b000);

    // ---- start during RUN does not alter stream length ----
    i_data = 8'd1; w_data = 8'd3; start = 1'b1;
    step();
    i_data = 8'd90; w_data = 8'd10;
    en_seen = 1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) start = 1'b0;
      step();
      if (en === 1'b1) en_seen++;
      if (done === 1'b1) begin
        done_seen = 1;
        break;
      end
    end
    start = 1'b0;
    chk("ign_start_done_seen", done_seen, 1);
    chk("ign_start_len", en_seen, 3);
    step(); chk("ign_start_idle", {busy, en}, 2'b00);

    // ---- asynchronous reset mid-RUN ----
    i_data = 8'h90; w_data = 8'd20; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_pre_run", {busy, en}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs, 8'h00);
    #3 rst_n = 1'b1;
    step(); chk("rst_release_idle1", outs, 8'h00);
    step(); chk("rst_release_idle2", outs, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
